// File: rtl/dm_hart_flags.sv
// Hart-side debug-memory flag and status block.
// Hosts the GO/RESUME flags the hart polls from its park loop, decodes the
// hart's acknowledge writes into one-cycle pulses for the DM control unit,
// and tracks the hart's debug state to drive halted_o and resumeack_o.
module dm_hart_flags (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        go_i,
  input  logic        resume_i,
  input  logic        ndmreset_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [11:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        rvalid_o,
  output logic        going_o,
  output logic        resuming_o,
  output logic        halted_int_o,
  output logic        exception_o,
  output logic        halted_o,
  output logic        resumeack_o
);

  // Word addresses (byte address >> 2) of the decoded locations.
  localparam logic [9:0] AddrHalted    = 10'h040;
  localparam logic [9:0] AddrGoing     = 10'h041;
  localparam logic [9:0] AddrResuming  = 10'h042;
  localparam logic [9:0] AddrException = 10'h043;
  localparam logic [9:0] AddrFlags     = 10'h100;

  typedef enum logic [1:0] {
    StRunning  = 2'd0,
    StHalted   = 2'd1,
    StExec     = 2'd2,
    StResuming = 2'd3
  } state_e;

  state_e      state_q;
  logic        halted_q;
  logic        go_flag_q;
  logic        resume_flag_q;
  logic        resumeack_q;
  logic        go_prev_q;
  logic        resume_prev_q;
  logic        edge_arm_q;
  logic        going_q;
  logic        resuming_q;
  logic        halted_int_q;
  logic        exception_q;
  logic        rvalid_q;
  logic [31:0] rdata_q;

  logic        go_flag_d;
  logic        resume_flag_d;
  logic        resumeack_d;

  logic [9:0]  word_addr;
  logic        wr_halted;
  logic        wr_going;
  logic        wr_resuming;
  logic        wr_exception;
  logic        rd_flags;
  logic        go_edge;
  logic        resume_edge;

  // Write data carries no information for any decoded location.
  logic        unused_wdata;
  assign unused_wdata = ^{wdata_i, addr_i[1:0]};

  // Access decode; the byte offset within a word is ignored.
  always_comb begin
    word_addr    = addr_i[11:2];
    wr_halted    = req_i & we_i & (word_addr == AddrHalted);
    wr_going     = req_i & we_i & (word_addr == AddrGoing);
    wr_resuming  = req_i & we_i & (word_addr == AddrResuming);
    wr_exception = req_i & we_i & (word_addr == AddrException);
    rd_flags     = req_i & ~we_i & (word_addr == AddrFlags);
  end

  // Rising-edge detect on the control-unit levels. edge_arm_q stays low for
  // the first cycle after reset so a level already high at release is only
  // captured, not treated as a new request.
  always_comb begin
    go_edge     = go_i & ~go_prev_q & edge_arm_q;
    resume_edge = resume_i & ~resume_prev_q & edge_arm_q;
  end

  // Edge-detect history registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      go_prev_q     <= 1'b0;
      resume_prev_q <= 1'b0;
      edge_arm_q    <= 1'b0;
    end else begin
      go_prev_q     <= go_i;
      resume_prev_q <= resume_i;
      edge_arm_q    <= 1'b1;
    end
  end

  // Flag next state: (flag & ~clear) | set, so a coincident set wins.
  // ndmreset_i overrides everything.
  always_comb begin
    go_flag_d     = (go_flag_q & ~(wr_going | wr_exception)) | go_edge;
    resume_flag_d = (resume_flag_q & ~wr_resuming) | resume_edge;
    resumeack_d   = (resumeack_q & ~resume_edge) | wr_resuming;
    if (ndmreset_i) begin
      go_flag_d     = 1'b0;
      resume_flag_d = 1'b0;
      resumeack_d   = 1'b0;
    end
  end

  // Flag and sticky-acknowledge registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      go_flag_q     <= 1'b0;
      resume_flag_q <= 1'b0;
      resumeack_q   <= 1'b0;
    end else begin
      go_flag_q     <= go_flag_d;
      resume_flag_q <= resume_flag_d;
      resumeack_q   <= resumeack_d;
    end
  end

  // Hart debug-state FSM with registered halted level. A RESUMING write
  // always lands in RUNNING so halted_o drops on every resume acknowledge,
  // not only when the hart was already in the resuming state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StRunning;
      halted_q <= 1'b0;
    end else if (ndmreset_i) begin
      state_q  <= StRunning;
      halted_q <= 1'b0;
    end else if (wr_halted) begin
      state_q  <= StHalted;
      halted_q <= 1'b1;
    end else if (wr_resuming) begin
      state_q  <= StRunning;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        StHalted: begin
          if (wr_going) begin
            state_q  <= StExec;
            halted_q <= 1'b1;
          end else if (resume_flag_q) begin
            state_q  <= StResuming;
            halted_q <= 1'b0;
          end
        end
        StExec: begin
          if (wr_exception) begin
            state_q  <= StHalted;
            halted_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= state_q;
          halted_q <= halted_q;
        end
      endcase
    end
  end

  // Acknowledge pulses, one cycle per triggering write, muted by ndmreset_i.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      going_q      <= 1'b0;
      resuming_q   <= 1'b0;
      halted_int_q <= 1'b0;
      exception_q  <= 1'b0;
    end else begin
      going_q      <= wr_going & ~ndmreset_i;
      resuming_q   <= wr_resuming & ~ndmreset_i;
      halted_int_q <= wr_halted & ~ndmreset_i;
      exception_q  <= wr_exception & ~ndmreset_i;
    end
  end

  // Access response: every access answers next cycle; only FLAGS returns data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rdata_q  <= 32'h0;
    end else begin
      rvalid_q <= req_i;
      rdata_q  <= rd_flags ? {30'b0, resume_flag_q, go_flag_q} : 32'h0;
    end
  end

  assign rdata_o      = rdata_q;
  assign rvalid_o     = rvalid_q;
  assign going_o      = going_q;
  assign resuming_o   = resuming_q;
  assign halted_int_o = halted_int_q;
  assign exception_o  = exception_q;
  assign halted_o     = halted_q;
  assign resumeack_o  = resumeack_q;

endmodule

// File: doc/dm_hart_flags.md
DM_HART_FLAGS -- requirements
Module: dm_hart_flags

Interface
REQ-001 clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-002 rst_ni  in  1  asynchronous, active-low reset.
REQ-003 go_i  in  1  level from the DM control unit; held high while that unit waits in its GO state.
REQ-004 resume_i  in  1  level from the DM control unit; held high while that unit waits in its RESUME state.
REQ-005 ndmreset_i  in  1  synchronous clear of all hart-side flags and status.
REQ-006 req_i  in  1  hart debug-memory access strobe, one cycle per access.
REQ-007 we_i  in  1  access is a write when 1.
REQ-008 addr_i  in  12  byte address within debug memory; bits [1:0] ignored.
REQ-009 wdata_i  in  32  write data, ignored for all decoded writes.
REQ-010 rdata_o  out  32  read data, valid with rvalid_o.
REQ-011 rvalid_o  out  1  access response, one cycle after req_i.
REQ-012 going_o  out  1  one-cycle pulse: hart acknowledged GO.
REQ-013 resuming_o  out  1  one-cycle pulse: hart acknowledged RESUME.
REQ-014 halted_int_o  out  1  one-cycle pulse: hart entered or re-entered the park loop.
REQ-015 exception_o  out  1  one-cycle pulse: exception while executing the abstract command or program buffer.
REQ-016 halted_o  out  1  level: hart is in debug mode.
REQ-017 resumeack_o  out  1  sticky: last resume request completed.

Function
REQ-018 Address map: 0x100 HALTED(W), 0x104 GOING(W), 0x108 RESUMING(W), 0x10C EXCEPTION(W), 0x400 FLAGS(R); all other addresses read 0 and ignore writes.
REQ-019 FLAGS read data SHALL be {30'b0, resume_flag, go_flag}, sampled in the req_i cycle and returned on the next cycle with rvalid_o=1.
REQ-020 rvalid_o SHALL pulse one cycle after every req_i, for reads and writes; rdata_o=0 for writes and unmapped reads.
REQ-021 go_flag SHALL set on the rising edge of go_i (go_i=1 with go_i in the previous cycle =0); a held-high go_i SHALL NOT re-set the flag.
REQ-022 resume_flag SHALL set on the rising edge of resume_i, by the same rule.
REQ-023 A write to GOING SHALL clear go_flag and pulse going_o in the following cycle.
REQ-024 A write to RESUMING SHALL clear resume_flag, clear halted_o, set resumeack_o, and pulse resuming_o in the following cycle.
REQ-025 A write to HALTED SHALL set halted_o and pulse halted_int_o in the following cycle.
REQ-026 A write to EXCEPTION SHALL clear go_flag and pulse exception_o in the following cycle.
REQ-027 A rising edge of resume_i SHALL clear resumeack_o.
REQ-028 Flag update rule: next = (flag & ~clear) | set; a set and a clear in the same cycle leaves the flag set.
REQ-029 Hart state FSM, 2 bits: RUNNING (reset), HALTED, EXEC, RESUMING.
REQ-030 FSM transitions:
- RUNNING -> HALTED on a HALTED write.
- HALTED -> EXEC on a GOING write.
- HALTED -> RESUMING when resume_flag=1.
- EXEC -> HALTED on a HALTED or EXCEPTION write.
- RESUMING -> RUNNING on a RESUMING write.
- A HALTED write in any state -> HALTED.
REQ-031 halted_o SHALL be 1 in states HALTED and EXEC, and 0 otherwise.
REQ-032 go_i rising edges while the FSM is not HALTED SHALL still set go_flag; gating is the control unit's responsibility.
REQ-033 ndmreset_i=1 SHALL:
- clear go_flag, resume_flag, halted_o and resumeack_o;
- force RUNNING;
- suppress all pulses in that cycle;
- take priority over every concurrent write.
REQ-034 Output pulses SHALL be registered, each exactly one cycle wide per triggering write; back-to-back writes yield back-to-back pulses.

Reset
REQ-035 While rst_ni=0:
- go_flag, resume_flag and all pulse outputs = 0;
- halted_o, resumeack_o, rvalid_o = 0;
- rdata_o = 0;
- FSM = RUNNING;
- edge-detect registers = 0.
REQ-036 Release of rst_ni SHALL NOT create a go/resume edge if go_i or resume_i is already high.

Verification
REQ-037 Write HALTED -> halted_int_o pulses 1 cycle later and halted_o=1; go_i rises -> FLAGS read returns 0x1; write GOING -> going_o pulses, FLAGS returns 0x0.
REQ-038 From HALTED, resume_i rises and is held -> FLAGS=0x2 and resumeack_o=0; write RESUMING -> resuming_o pulses, halted_o=0, resumeack_o=1, FLAGS=0x0, with no re-set while resume_i remains high.
REQ-039 In EXEC, write EXCEPTION -> exception_o pulses once, go_flag=0, FSM returns to HALTED, halted_o stays 1.
REQ-040 go_i rising edge in the same cycle as a GOING write -> go_flag=1 afterwards, going_o pulses.
REQ-041 ndmreset_i asserted in the same cycle as a HALTED write with both flags set -> no halted_int_o pulse, FLAGS=0x0, halted_o=0, FSM=RUNNING.
REQ-042 Read of unmapped address 0x200 and write to 0x400 -> rvalid_o pulses 1 cycle later, rdata_o=0, no state change; rst_ni pulsed low mid-EXEC -> all outputs 0 immediately.
